// File: rtl/uart_pkg.sv
// Frame constants and helpers shared by the UART transmit and receive paths.
package uart_pkg;

  localparam int   FRAME_BITS = 12;
  localparam int   STOP_BITS  = 2;
  localparam logic START_BIT  = 1'b0;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BAUD-1 and ticks on the terminal count.
module uart_baud_gen #(
  parameter int CLKS_PER_BAUD = 15259
) (
  input  logic ref_clk,
  input  logic reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BAUD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = w_tc & ~i_restart;

  // Restart holds the count at zero so the first bit gets a full period.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_restart || w_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART tx line among N_REQ requesters; 12-bit frames, MSB first.
// Define UART_TX_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int CLKS_PER_BAUD = 15259,
  parameter int GAP_BAUDS     = 1
) (
  input  logic                     ref_clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       data,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ser_out
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LAST = (GAP_BAUDS > 0) ? 4'(GAP_BAUDS - 1) : 4'd0;

  tx_state_t             r_state, w_state_next;
  logic [FRAME_BITS-1:0] r_shift, w_shift_next;
  logic [3:0]            r_bit_cnt, w_bit_next;
  logic [3:0]            r_gap_cnt, w_gap_next;
  logic [N_REQ-1:0]      r_ack, w_ack_next;
  logic [ID_W-1:0]       r_grant, w_grant_next;
  logic                  r_busy, w_busy_next;
  logic                  r_done, w_done_next;
  logic [ID_W-1:0]       w_win;
  logic                  w_any;
  logic                  w_tick;
  logic [N_REQ-1:0][7:0] w_bytes;
`ifndef UART_TX_FIXED_PRIO_EN
  logic [ID_W-1:0]       r_ptr, w_ptr_next;
`endif

  assign w_bytes    = data;
  assign ack        = r_ack;
  assign grant_id   = r_grant;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign ser_out    = r_shift[FRAME_BITS-1];

  uart_baud_gen #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_baud (
    .ref_clk  (ref_clk),
    .reset_n  (reset_n),
    .i_restart(r_state == IDLE),
    .o_tick   (w_tick)
  );

  // Scan from the highest candidate down so the first hit in priority order lands last.
  always_comb begin
    logic [ID_W-1:0] idx;
    w_any = 1'b0;
    w_win = '0;
    idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
`ifdef UART_TX_FIXED_PRIO_EN
      idx = ID_W'(k);
`else
      idx = ID_W'((int'(r_ptr) + k) % N_REQ);
`endif
      if (req[idx]) begin
        w_win = idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_cnt;
    w_gap_next   = r_gap_cnt;
    w_ack_next   = '0;
    w_grant_next = r_grant;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
`ifndef UART_TX_FIXED_PRIO_EN
    w_ptr_next   = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_ack_next[w_win] = 1'b1;
          w_grant_next      = w_win;
          w_busy_next       = 1'b1;
          w_shift_next      = {START_BIT, w_bytes[w_win], even_parity(w_bytes[w_win]),
                               {STOP_BITS{IDLE_LEVEL}}};
          w_bit_next        = 4'd0;
          w_state_next      = SHIFT;
`ifndef UART_TX_FIXED_PRIO_EN
          w_ptr_next        = ID_W'((int'(w_win) + 1) % N_REQ);
`endif
        end
      end
      SHIFT: begin
        if (w_tick) begin
          w_shift_next = {r_shift[FRAME_BITS-2:0], IDLE_LEVEL};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_next  = 4'd0;
            w_done_next = 1'b1;
            if (GAP_BAUDS == 0) begin
              w_state_next = IDLE;
              w_busy_next  = 1'b0;
            end else begin
              w_state_next = GAP;
              w_gap_next   = 4'd0;
            end
          end else begin
            w_bit_next = r_bit_cnt + 4'd1;
          end
        end
      end
      GAP: begin
        if (w_tick) begin
          if (r_gap_cnt == GAP_LAST) begin
            w_state_next = IDLE;
            w_busy_next  = 1'b0;
          end else begin
            w_gap_next = r_gap_cnt + 4'd1;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Reset forces the line to mark at once; an in-flight frame is simply dropped.
  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_shift   <= '1;
      r_bit_cnt <= 4'd0;
      r_gap_cnt <= 4'd0;
      r_ack     <= '0;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifndef UART_TX_FIXED_PRIO_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_bit_cnt <= w_bit_next;
      r_gap_cnt <= w_gap_next;
      r_ack     <= w_ack_next;
      r_grant   <= w_grant_next;
      r_busy    <= w_busy_next;
      r_done    <= w_done_next;
`ifndef UART_TX_FIXED_PRIO_EN
      r_ptr     <= w_ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, multi-cycle corner cases, randomized rounds vs. model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int C  = 4;
  localparam int G  = 1;
  localparam int DONE_N = 12 * C;
  localparam int IDLE_N = 12 * C + G * C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req, req0;
  logic [31:0] data, data0;
  logic [3:0]  ack, ack0;
  logic [1:0]  grant, grant0;
  logic        busy, busy0, done, done0, ser, ser0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BAUD(C), .GAP_BAUDS(G)) dut (
    .ref_clk(clk), .reset_n(reset_n), .req(req), .data(data), .ack(ack),
    .grant_id(grant), .busy(busy), .frame_done(done), .ser_out(ser)
  );

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BAUD(C), .GAP_BAUDS(0)) dut0 (
    .ref_clk(clk), .reset_n(reset_n), .req(req0), .data(data0), .ack(ack0),
    .grant_id(grant0), .busy(busy0), .frame_done(done0), .ser_out(ser0)
  );

  typedef struct {
    bit         rst;
    logic [3:0] mask;
    int         id;
    logic [11:0] frame;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [11:0] model_frame(input logic [7:0] d);
    int   ones = 0;
    logic p;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = (ones % 2) == 1;
    return {1'b0, d, p, 2'b11};
  endfunction

  function automatic int model_pick(input logic [3:0] mask, input int ptr);
`ifdef UART_TX_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (mask[i[1:0]]) return i;
`else
    for (int k = 0; k < N; k++) begin
      int i = (ptr + k) % N;
      if (mask[i[1:0]]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Waits for one ack, then decodes and times the whole frame up to the IDLE cycle.
  task automatic serve(input int exp_id, input logic [11:0] exp_frame, input int late_n,
                       input logic [3:0] late_mask, input string tag);
    int          k;
    int          done_n, busy_n, extra;
    logic [11:0] fr;
    logic [3:0]  exp_ack;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack == 4'b0 && k < 200);
    if (ack == 4'b0) begin
      check($sformatf("%s_ack_timeout", tag), 32'd0, 32'd1);
      return;
    end
    exp_ack = 4'b0001 << exp_id;
    check($sformatf("%s_ack", tag), 32'(ack), 32'(exp_ack));
    check($sformatf("%s_grant", tag), 32'(grant), 32'(exp_id));
    fr = '0; done_n = -1; busy_n = -1; extra = 0;
    for (int n = 0; n <= IDLE_N; n++) begin
      if (n > 0) @(negedge clk);
      if (n == late_n) req = late_mask;
      if (n > 0 && ack != 4'b0) extra++;
      if (n < DONE_N && n % C == 1) fr = {fr[10:0], ser};
      if (done && done_n < 0) done_n = n;
      if (!busy && busy_n < 0) busy_n = n;
    end
    check($sformatf("%s_frame", tag), 32'(fr), 32'(exp_frame));
    check($sformatf("%s_done_time", tag), 32'(done_n), 32'(DONE_N));
    check($sformatf("%s_busy_low_time", tag), 32'(busy_n), 32'(IDLE_N));
    check($sformatf("%s_extra_acks", tag), 32'(extra), 32'd0);
    $display("txn %s: id=%0d frame=%03h done@%0d busy_low@%0d", tag, grant, fr, done_n, busy_n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          k, mptr, exp, keep, done_seen, ack_seen;
    logic [3:0]  cur, nb, nxt;
    logic [11:0] fr;

    tbl[0] = '{1'b1, 4'b0001, 0, 12'h52B};
    tbl[1] = '{1'b0, 4'b0010, 1, 12'h00F};
    tbl[2] = '{1'b1, 4'b1111, 0, 12'h52B};
`ifdef UART_TX_FIXED_PRIO_EN
    tbl[3] = '{1'b0, 4'b1111, 0, 12'h52B};
    tbl[4] = '{1'b0, 4'b1111, 0, 12'h52B};
    tbl[5] = '{1'b0, 4'b1111, 0, 12'h52B};
`else
    tbl[3] = '{1'b0, 4'b1111, 1, 12'h00F};
    tbl[4] = '{1'b0, 4'b1111, 2, 12'h1E3};
    tbl[5] = '{1'b0, 4'b1111, 3, 12'h7FB};
`endif
    tbl[6] = '{1'b0, 4'b1111, 0, 12'h52B};

    reset_n = 1'b1;
    req     = 4'b0;
    req0    = 4'b0;
    data    = {8'hFF, 8'h3C, 8'h01, 8'hA5};
    data0   = {8'hFF, 24'h0};
    #1 reset_n = 1'b0;
    #1;
    check("reset_ser_out", 32'(ser), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ack", 32'(ack), 32'd0);
    check("reset_frame_done", 32'(done), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].rst) do_reset();
      req = tbl[i].mask;
      serve(tbl[i].id, tbl[i].frame, -1, 4'b0, $sformatf("vec%0d", i));
    end
    req = 4'b0;

    // Late requester arrives mid-frame and must wait for IDLE.
    do_reset();
    req = 4'b0001;
    serve(0, 12'h52B, 10, 4'b0100, "late_r0");
    serve(2, 12'h1E3, -1, 4'b0, "late_r2");
    req = 4'b1111;
`ifdef UART_TX_FIXED_PRIO_EN
    serve(0, 12'h52B, 1, 4'b0, "late_wrap");
`else
    serve(3, 12'h7FB, 1, 4'b0, "late_wrap");
`endif

    // Reset in the middle of bit 5.
    req = 4'b0001;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack == 4'b0 && k < 200);
    check("midrst_ack", 32'(ack), 32'h1);
    repeat (21) @(negedge clk);
    check("midrst_bit5_low", 32'(ser), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_ser_high", 32'(ser), 32'd1);
    check("midrst_busy_low", 32'(busy), 32'd0);
    req = 4'b0;
    done_seen = 0;
    ack_seen  = 0;
    repeat (3) begin
      @(negedge clk);
      done_seen |= int'(done);
    end
    reset_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      done_seen |= int'(done);
      ack_seen  |= int'(ack != 4'b0);
    end
    check("midrst_no_frame_done", 32'(done_seen), 32'd0);
    check("midrst_no_ack", 32'(ack_seen), 32'd0);
    check("midrst_idle_line", 32'(ser), 32'd1);
    req = 4'b0010;
    serve(1, 12'h00F, 1, 4'b0, "post_rst");

    // Randomized rounds against the arbitration and framing model.
    do_reset();
    mptr = 0;
    cur  = 4'b0;
    for (int r = 0; r < 16; r++) begin
      nb = 4'($urandom_range(0, 15)) & ~cur;
      if ((cur | nb) == 4'b0) nb = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < N; i++) if (nb[i[1:0]]) data[8*i +: 8] = 8'($urandom);
      cur = cur | nb;
      req = cur;
      exp = model_pick(cur, mptr);
`ifndef UART_TX_FIXED_PRIO_EN
      mptr = (exp + 1) % N;
`endif
      keep = int'($urandom_range(0, 1));
      nxt  = (keep != 0) ? cur : (cur & ~(4'b0001 << exp));
      serve(exp, model_frame(data[8*exp +: 8]), 1, nxt, $sformatf("rnd%0d", r));
      cur = nxt;
    end
    req = 4'b0;

    // Back-to-back frames with no gap on the second instance.
    req0 = 4'b1000;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (ack0 == 4'b0 && k < 200);
    check("b2b_first_ack", 32'(ack0), 32'h8);
    for (int f = 0; f < 2; f++) begin
      fr = '0;
      for (int n = 0; n < DONE_N; n++) begin
        if (n > 0) @(negedge clk);
        if (n % C == 1) fr = {fr[10:0], ser0};
      end
      @(negedge clk);
      check($sformatf("b2b%0d_frame", f), 32'(fr), 32'(model_frame(8'hFF)));
      check($sformatf("b2b%0d_done", f), 32'(done0), 32'd1);
      check($sformatf("b2b%0d_mark", f), 32'(ser0), 32'd1);
      @(negedge clk);
      check($sformatf("b2b%0d_next_start", f), 32'(ser0), 32'd0);
      check($sformatf("b2b%0d_next_ack", f), 32'(ack0), 32'h8);
      $display("txn b2b%0d: frame=%03h", f, fr);
    end
    req0 = 4'b0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Transmit-side scheduler that shares one UART serial line between N_REQ on-chip requesters.
- Round-robin arbitration picks a requester, captures its byte, and serializes it in the 12-bit frame format that Rx_protocol_top receives. Bits go MSB first and each bit lasts CLKS_PER_BAUD ref_clk cycles.
- Sits between host-side byte producers and the ser_out pad, and is the loopback source for the Rx path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BAUD, 15259, ref_clk cycles per bit (500 MHz / 32768 bps); must be >= 2.
- GAP_BAUDS, 1, idle (mark) bit times inserted after each frame (0..15).

Ports:
- ref_clk  in  1  design reference clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester transmit request; held high with data stable until ack.
- data  in  8*N_REQ  flat byte bus; requester i uses data[8*i+7:8*i].
- ack  out  N_REQ  one-cycle pulse: byte of that requester captured.
- grant_id  out  clog2(N_REQ)  index of the requester currently or last served.
- busy  out  1  high from capture through the end of the gap.
- frame_done  out  1  one-cycle pulse when the last stop bit ends.
- ser_out  out  1  serial line; idle = 1.

Behaviour:
- Frame layout, transmitted in this order (12 bits):
  - start bit 0;
  - d[7:0], MSB first;
  - even parity (XOR of d);
  - two stop bits of 1.
- Reset (async assert, sync-release usage):
  - ser_out=1, ack=0, busy=0, frame_done=0, grant_id=0.
  - Round-robin pointer = 0; state = IDLE.
- States and transitions:
  - IDLE -> SHIFT -> GAP -> IDLE.
  - GAP is skipped when GAP_BAUDS=0.
- Capture (IDLE, cycle t, req!=0):
  - Winner is the first set req at or above the pointer, wrapping modulo N_REQ.
  - At t+1: ack[winner]=1, grant_id=winner, busy=1, 12-bit shift register loaded, ser_out=0 (start bit), baud counter=0.
  - Pointer becomes winner+1 (mod N_REQ).
- SHIFT:
  - Baud counter counts 0..CLKS_PER_BAUD-1.
  - On terminal count, shift to the next bit.
  - After bit 12 ends: ser_out=1, frame_done pulse on that cycle.
  - Then go to GAP, or to IDLE if GAP_BAUDS=0.
- Frame timing: start of start bit to frame_done = 12*CLKS_PER_BAUD cycles.
- GAP:
  - ser_out=1 for GAP_BAUDS*CLKS_PER_BAUD cycles.
  - busy drops on the last GAP cycle; return to IDLE.
- Back-to-back (GAP_BAUDS=0):
  - A req pending at frame end is arbitrated in the IDLE cycle.
  - Minimum 1 idle-mark cycle between frames.
- req sampling:
  - req is sampled only in IDLE; req changes during SHIFT/GAP are ignored.
  - A req dropped before ack is never served; a req still high after ack is served again by round-robin.
- Simultaneous requests: only one ack per capture; all other requests stay pending.
- Reset mid-frame: ser_out returns to 1 immediately, the frame is abandoned, and no frame_done is generated.
- Width rules:
  - Baud counter width = clog2(CLKS_PER_BAUD).
  - Bit counter is 4 bits; gap counter is 4 bits.
  - No overflow is possible within the legal parameter ranges.

Optional Feature:
- Macro: UART_TX_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set req index always wins and the round-robin pointer is not implemented.
- Undefined: round-robin as specified above.

Decomposition:
- Shared package uart_pkg:
  - FRAME_BITS=12, STOP_BITS=2, START_BIT=1'b0, IDLE_LEVEL=1'b1;
  - state enum {IDLE, SHIFT, GAP};
  - parity function (even XOR).
- These constants are shared with Rx_protocol_top.
- One sub-module: uart_baud_gen (counter plus terminal-count tick, with a restart input). Arbitration and the FSM stay in the top.

Test Plan (sim with CLKS_PER_BAUD=4, GAP_BAUDS=1, N_REQ=4):
- Single request, req=4'b0001, data byte0=0xA5:
  - ack[0] pulses 1 cycle after req.
  - ser_out bit sequence equals 12'h52B (0_10100101_0_11).
  - frame_done 48 cycles after the start bit begins; busy low 4 cycles later.
- Parity check, byte1=0x01 on req[1] -> frame 12'h00F (parity=1); grant_id=1.
- Fairness, req=4'b1111 held continuously:
  - Ack order 0,1,2,3,0.
  - With UART_TX_FIXED_PRIO_EN defined: 0,0,0.
- Late requester:
  - req[2] asserted during SHIFT of a requester-0 frame is not acked until IDLE.
  - Next ack is ack[2], then the pointer wraps to 3.
- Reset mid-frame:
  - reset_n low at bit 5: ser_out=1 within the same delta and busy=0, with no frame_done.
  - After release, a new req yields a complete, correct frame.
- Back-to-back, GAP_BAUDS=0, req[3] held with data 0xFF:
  - Frames 12'h7FB each.
  - Exactly 1 cycle of ser_out=1 between the last stop bit and the next start bit.
